jesd207_tx_framer: RTL and testbench
====================================

JESD207_TX_FRAMER -- requirements
Module: jesd207_tx_framer

Interface
REQ-001 SHALL have parameter DATA_WID, default 12, meaning sample width in bits; one FIFO word carries one I or Q sample.
REQ-002 SHALL have parameter UCNT_WID, default 16, meaning the width of the underrun counter.
REQ-003 SHALL have port clk, input, 1: the single clock. Everything is synchronous to its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1: start or continue transmission.
REQ-006 SHALL have port mode, input, 1: 0 selects 1R1T (frame = I,Q); 1 selects 2R2T (frame = I1,Q1,I2,Q2).
REQ-007 SHALL have port rempty, input, 1: FIFO read-side empty flag.
REQ-008 SHALL have port rdata, input, DATA_WID: FIFO read data, valid one cycle after rinc.
REQ-009 SHALL have port rinc, output, 1: FIFO pop request.
REQ-010 SHALL have port tx_d, output, DATA_WID: JESD207 transmit data bus.
REQ-011 SHALL have port tx_frame, output, 1: JESD207 TX_FRAME.
REQ-012 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-013 SHALL have port underrun, output, 1: one-cycle pulse per starved slot.
REQ-014 SHALL have port underrun_cnt, output, UCNT_WID: saturating count of starved slots.

Function
REQ-015 SHALL implement states IDLE, PRIME, RUN, PAD and DRAIN.
REQ-016 IDLE: when en=1, SHALL latch mode into mode_q and go to PRIME; mode changes outside IDLE SHALL be ignored.
REQ-017 PRIME: SHALL wait while rempty=1; on the first cycle with rempty=0, SHALL assert rinc, set phase=0 and go to RUN. If en=0, SHALL return to IDLE.
REQ-018 Frame length L SHALL be 2 when mode_q=0 and 4 when mode_q=1; the phase counter SHALL wrap from L-1 to 0.
REQ-019 RUN: phase SHALL advance every cycle; rinc SHALL equal !rempty.
REQ-020 RUN, on a cycle with rempty=1: the slot is starved; SHALL assert underrun, increment underrun_cnt (saturating at all-ones), and go to PAD unless phase=L-1, in which case SHALL go to PRIME.
REQ-021 PAD: rinc=0; each remaining slot of the current frame SHALL transmit zero and does not count as an underrun; at phase=L-1, SHALL go to PRIME.
REQ-022 RUN with en=0: SHALL go to DRAIN. DRAIN SHALL keep reading until phase=L-1 (a starved slot there counts as underrun) and then go to IDLE. Frames are never truncated.
REQ-023 Latency: a slot issued at cycle n (rinc or starve) SHALL appear on tx_d/tx_frame at cycle n+2. tx_d SHALL be rdata, or zero for starved/pad slots.
REQ-024 tx_frame SHALL be 1 for slot phases 0 (1R1T) and 0..1 (2R2T), otherwise 0. It SHALL be 0 while no slot is in the pipeline.
REQ-025 tx_d SHALL be zero and tx_frame 0 for every cycle without an issued slot (IDLE/PRIME bubbles).
REQ-026 rinc SHALL never be asserted while rempty=1.
REQ-027 busy SHALL cover the two-cycle output pipeline tail after the return to IDLE.

Reset
REQ-028 rst=1 SHALL force IDLE with phase=0, mode_q=0, pipeline valid bits cleared, rinc=0, tx_d=0, tx_frame=0, underrun=0, underrun_cnt=0 and busy=0 on the next edge.
REQ-029 rst mid-frame SHALL abort immediately with no drain; the partial frame is lost.

Structure
REQ-030 A shared package SHALL hold the state enum, the MODE_1R1T/MODE_2R2T constants and the frame-length function.
REQ-031 No sub-module; the phase counter and the 2-stage slot pipeline (valid, phase, zero flag) are inline.

Verification
REQ-032 1R1T, 6 words 0x101..0x106 preloaded, en=1 -> tx_d 101..106 starting 3 cycles after en; tx_frame 1,0,1,0,1,0; then PRIME with rempty=1 and underrun=1 once.
REQ-033 2R2T, 8 words -> tx_frame 1,1,0,0,1,1,0,0, data in order, underrun_cnt=0 if en drops after word 8.
REQ-034 2R2T, FIFO empties after word 2 -> slot 3 zero with underrun pulse, slot 4 zero (PAD) with no pulse, then PRIME; underrun_cnt=1.
REQ-035 en deasserted at phase 1 of a 2R2T frame -> slots 2..3 still issued, then IDLE; busy falls 2 cycles later.
REQ-036 rst asserted mid-RUN -> next cycle all outputs zero and state IDLE; force underrun_cnt to all-ones plus one starve -> stays all-ones.

Source files
------------

// File: rtl/jesd207_tx_framer_pkg.sv
// rtl/jesd207_tx_framer_pkg.sv - shared types and helpers for the JESD207 TX framer
//
// Purpose: framer state encoding, antenna-mode constants and frame-geometry
//          helpers shared by the framer and anything that models it.
// Ports:   none (package).
package jesd207_tx_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAD   = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam logic MODE_1R1T = 1'b0;
    localparam logic MODE_2R2T = 1'b1;

    // Phase index of the final slot of a frame (L-1).
    function automatic logic [1:0] frame_last(input logic mode);
        return (mode == MODE_2R2T) ? 2'd3 : 2'd1;
    endfunction

    // TX_FRAME is high for the first half of the frame: I in 1R1T, I1/Q1 in 2R2T.
    function automatic logic frame_flag(input logic [1:0] phase, input logic mode);
        return (mode == MODE_2R2T) ? (phase < 2'd2) : (phase == 2'd0);
    endfunction

endpackage

// File: rtl/jesd207_tx_framer.sv
// rtl/jesd207_tx_framer.sv - JESD207 transmit framer fed from a sample FIFO
//
// Purpose: pops I/Q samples from a FIFO and emits them on the JESD207 TX bus
//          with TX_FRAME marking, padding starved frames with zeros so a frame
//          is never truncated.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   en                - start/continue transmission; dropping it drains the frame
//   mode              - 0: 1R1T (I,Q), 1: 2R2T (I1,Q1,I2,Q2); sampled when leaving IDLE
//   rempty, rdata     - FIFO read side; rdata valid the cycle after rinc
//   rinc              - FIFO pop request
//   tx_d, tx_frame    - JESD207 transmit data and TX_FRAME, two cycles after slot issue
//   busy              - active, including the output pipeline tail
//   underrun          - one-cycle pulse (cycle after the slot) per starved slot
//   underrun_cnt      - saturating count of starved slots
module jesd207_tx_framer
    import jesd207_tx_framer_pkg::*;
#(
    parameter int DATA_WID = 12,
    parameter int UCNT_WID = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mode,
    input  logic                rempty,
    input  logic [DATA_WID-1:0] rdata,
    output logic                rinc,
    output logic [DATA_WID-1:0] tx_d,
    output logic                tx_frame,
    output logic                busy,
    output logic                underrun,
    output logic [UCNT_WID-1:0] underrun_cnt
);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  phase;        // phase of the next slot issued in RUN/PAD/DRAIN
    logic [1:0]  slot_phase;   // phase of the slot issued this cycle
    logic        slot_last;
    logic        mode_q;
    logic        issue;
    logic        rd;
    logic        starve;
    logic        pad_slot;

    // Stage 1: slot issued last cycle; its sample is on rdata now.
    logic        s1_valid;
    logic [1:0]  s1_phase;
    logic        s1_zero;
    logic        s1_mode;
    // Stage 2: slot currently on tx_d/tx_frame.
    logic        s2_valid;

    // PRIME always issues the first slot of a frame.
    always_comb begin
        slot_phase = (state == ST_PRIME) ? 2'd0 : phase;
        slot_last  = (slot_phase == frame_last(mode_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (en) state_nxt = ST_PRIME;
            end
            ST_PRIME: begin
                if (!en)          state_nxt = ST_IDLE;
                else if (!rempty) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // Starvation wins over en: the frame is completed with pad
                // slots and PRIME then sees en low and returns to IDLE.
                if (rempty)   state_nxt = slot_last ? ST_PRIME : ST_PAD;
                else if (!en) state_nxt = slot_last ? ST_IDLE : ST_DRAIN;
            end
            ST_PAD: begin
                if (slot_last) state_nxt = ST_PRIME;
            end
            ST_DRAIN: begin
                if (slot_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        issue    = 1'b0;
        rd       = 1'b0;
        starve   = 1'b0;
        pad_slot = 1'b0;
        case (state)
            ST_PRIME: begin
                if (en && !rempty) begin
                    issue = 1'b1;
                    rd    = 1'b1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                issue  = 1'b1;
                rd     = !rempty;
                starve = rempty;
            end
            ST_PAD: begin
                issue    = 1'b1;
                pad_slot = 1'b1;
            end
            default: ;
        endcase
    end

    // Never pop the FIFO on a reset cycle: the data would be lost.
    assign rinc = rd & ~rst;
    assign busy = (state != ST_IDLE) | s1_valid | s2_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase        <= 2'd0;
            mode_q       <= MODE_1R1T;
            s1_valid     <= 1'b0;
            s1_phase     <= 2'd0;
            s1_zero      <= 1'b0;
            s1_mode      <= MODE_1R1T;
            s2_valid     <= 1'b0;
            tx_d         <= '0;
            tx_frame     <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            if (state == ST_IDLE) begin
                phase <= 2'd0;
                if (en) mode_q <= mode;
            end else if (issue) begin
                phase <= slot_last ? 2'd0 : slot_phase + 2'd1;
            end

            s1_valid <= issue;
            s1_phase <= slot_phase;
            s1_zero  <= starve | pad_slot;
            // Captured per slot so a new mode latched during the tail
            // cannot re-mark slots still in flight.
            s1_mode  <= mode_q;

            s2_valid <= s1_valid;
            tx_d     <= (s1_valid && !s1_zero) ? rdata : '0;
            tx_frame <= s1_valid && frame_flag(s1_phase, s1_mode);

            underrun <= starve;
            if (starve && (underrun_cnt != '1)) begin
                underrun_cnt <= underrun_cnt + UCNT_WID'(1);
            end
        end
    end

endmodule

// File: tb/tb_jesd207_tx_framer.sv
// tb/tb_jesd207_tx_framer.sv - self-checking bench for the JESD207 TX framer
//
// Purpose: cycle-accurate scoreboard of busy/underrun/tx_frame/tx_d per
//          scenario, plus reset, abort and counter saturation checks.
// Ports:   none (top-level bench).
module tb_jesd207_tx_framer;

    localparam int DW = 12;
    localparam int UW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          mode = 1'b0;
    logic          rempty;
    logic [DW-1:0] rdata;
    logic          rinc;
    logic [DW-1:0] tx_d;
    logic          tx_frame;
    logic          busy;
    logic          underrun;
    logic [UW-1:0] underrun_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // FIFO model: rdata registered on rinc.
    logic [DW-1:0] mem [0:63];
    int            wptr = 0;
    int            rptr = 0;
    assign rempty = (wptr == rptr);

    always @(posedge clk) begin
        if (rst) begin
            rptr  <= 0;
            rdata <= '0;
        end else if (rinc) begin
            rdata <= mem[rptr % 64];
            rptr  <= rptr + 1;
        end
    end

    always #5 clk = ~clk;

    jesd207_tx_framer #(.DATA_WID(DW), .UCNT_WID(UW)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .rempty(rempty),
        .rdata(rdata), .rinc(rinc), .tx_d(tx_d), .tx_frame(tx_frame),
        .busy(busy), .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    // Scoreboard entry: {busy, underrun, tx_frame, tx_d}, one per cycle.
    logic [DW+2:0] exp_q [$];
    logic [DW+2:0] e;

    task automatic expect_cyc(input logic b, input logic u, input logic f, input logic [DW-1:0] d);
        exp_q.push_back({b, u, f, d});
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        mem[wptr % 64] = w;
        wptr = wptr + 1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; en = 1'b0; wptr = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wind_down(input string name);
        int k;
        en = 1'b0;
        k = 0;
        while (busy && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_wind_down busy=%b want 0 after %0d cycles", name, busy, k);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++;
        if ({rinc, busy, underrun, tx_frame, tx_d, underrun_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset rinc/busy/und/frm/d/cnt=%b/%b/%b/%b/%h/%0d want all 0",
                     rinc, busy, underrun, tx_frame, tx_d, underrun_cnt);
        end
    endtask

    task automatic test_1r1t();
        do_reset();
        mode = 1'b0;
        for (int i = 0; i < 6; i++) push_word(12'(12'h101 + i));
        expect_cyc(0, 0, 0, 0);
        expect_cyc(1, 0, 0, 0);
        expect_cyc(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) expect_cyc(1, i == 5, (i % 2) == 0, 12'(12'h101 + i));
        expect_cyc(1, 0, 1, 0);
        expect_cyc(1, 0, 0, 0);
        expect_cyc(1, 0, 0, 0);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            en = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (rinc && rempty) begin
                n_err++;
                $display("FAIL 1r1t_rinc_empty cyc %0d rinc=1 with rempty=1", c);
            end
            e = exp_q.pop_front();
            n_cmp++;
            if ({busy, underrun, tx_frame, tx_d} !== e) begin
                n_err++;
                $display("FAIL 1r1t cyc %0d busy/und/frm/d got %b/%b/%b/%h want %b/%b/%b/%h",
                         c, busy, underrun, tx_frame, tx_d, e[DW+2], e[DW+1], e[DW], e[DW-1:0]);
            end
        end
        n_cmp++;
        if (underrun_cnt !== 3'd1) begin
            n_err++;
            $display("FAIL 1r1t_cnt got %0d want 1", underrun_cnt);
        end
        wind_down("1r1t");
    endtask

    task automatic test_2r2t();
        logic [1:0] frm_pat;
        do_reset();
        mode = 1'b1;
        for (int i = 0; i < 8; i++) push_word(12'(12'h201 + i));
        expect_cyc(0, 0, 0, 0);
        expect_cyc(1, 0, 0, 0);
        expect_cyc(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            frm_pat = 2'(i);
            expect_cyc(1, 0, frm_pat < 2'd2, 12'(12'h201 + i));
        end
        expect_cyc(0, 0, 0, 0);
        expect_cyc(0, 0, 0, 0);
        for (int c = 0; c < 13; c++) begin
            @(posedge clk); #1;
            en = (c < 8);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({busy, underrun, tx_frame, tx_d} !== e) begin
                n_err++;
                $display("FAIL 2r2t cyc %0d busy/und/frm/d got %b/%b/%b/%h want %b/%b/%b/%h",
                         c, busy, underrun, tx_frame, tx_d, e[DW+2], e[DW+1], e[DW], e[DW-1:0]);
            end
        end
        n_cmp++;
        if (underrun_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL 2r2t_cnt got %0d want 0", underrun_cnt);
        end
    endtask

    task automatic test_starve_pad();
        do_reset();
        mode = 1'b1;
        push_word(12'h301);
        push_word(12'h302);
        expect_cyc(0, 0, 0, 0);
        expect_cyc(1, 0, 0, 0);
        expect_cyc(1, 0, 0, 0);
        expect_cyc(1, 0, 1, 12'h301);
        expect_cyc(1, 1, 1, 12'h302);
        expect_cyc(1, 0, 0, 0);
        expect_cyc(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) expect_cyc(1, 0, 0, 0);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            en = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (rinc && rempty) begin
                n_err++;
                $display("FAIL starve_rinc_empty cyc %0d rinc=1 with rempty=1", c);
            end
            e = exp_q.pop_front();
            n_cmp++;
            if ({busy, underrun, tx_frame, tx_d} !== e) begin
                n_err++;
                $display("FAIL starve cyc %0d busy/und/frm/d got %b/%b/%b/%h want %b/%b/%b/%h",
                         c, busy, underrun, tx_frame, tx_d, e[DW+2], e[DW+1], e[DW], e[DW-1:0]);
            end
        end
        n_cmp++;
        if (underrun_cnt !== 3'd1) begin
            n_err++;
            $display("FAIL starve_cnt got %0d want 1", underrun_cnt);
        end
        wind_down("starve");
    endtask

    task automatic test_drain();
        do_reset();
        mode = 1'b1;
        for (int i = 0; i < 8; i++) push_word(12'(12'h401 + i));
        expect_cyc(0, 0, 0, 0);
        expect_cyc(1, 0, 0, 0);
        expect_cyc(1, 0, 0, 0);
        expect_cyc(1, 0, 1, 12'h401);
        expect_cyc(1, 0, 1, 12'h402);
        expect_cyc(1, 0, 0, 12'h403);
        expect_cyc(1, 0, 0, 12'h404);
        expect_cyc(0, 0, 0, 0);
        expect_cyc(0, 0, 0, 0);
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            en = (c < 2);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({busy, underrun, tx_frame, tx_d} !== e) begin
                n_err++;
                $display("FAIL drain cyc %0d busy/und/frm/d got %b/%b/%b/%h want %b/%b/%b/%h",
                         c, busy, underrun, tx_frame, tx_d, e[DW+2], e[DW+1], e[DW], e[DW-1:0]);
            end
        end
        n_cmp++;
        if (rptr !== 4) begin
            n_err++;
            $display("FAIL drain_pops got %0d want 4", rptr);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        mode = 1'b0;
        for (int i = 0; i < 10; i++) push_word(12'(12'h501 + i));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            en = 1'b1;
        end
        rst = 1'b1;
        en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        wptr = 0;
        @(negedge clk);
        n_cmp++;
        if ({rinc, busy, underrun, tx_frame, tx_d, underrun_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_mid rinc/busy/und/frm/d/cnt=%b/%b/%b/%b/%h/%0d want all 0",
                     rinc, busy, underrun, tx_frame, tx_d, underrun_cnt);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({busy, tx_frame, tx_d} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_stays_idle busy/frm/d=%b/%b/%h want 0", busy, tx_frame, tx_d);
        end
    endtask

    task automatic test_saturate();
        int pulses;
        do_reset();
        mode = 1'b0;
        pulses = 0;
        @(posedge clk); #1;
        en = 1'b1;
        for (int it = 0; it < 9; it++) begin
            if (it > 0) begin
                @(posedge clk); #1;
            end
            push_word(12'(12'h601 + it));
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (underrun) pulses++;
                if (k < 3) begin
                    @(posedge clk); #1;
                end
            end
            if (it == 6) begin
                n_cmp++;
                if (underrun_cnt !== 3'd7) begin
                    n_err++;
                    $display("FAIL sat_at_max got %0d want 7", underrun_cnt);
                end
            end
        end
        n_cmp++;
        if (underrun_cnt !== 3'd7) begin
            n_err++;
            $display("FAIL sat_hold got %0d want 7", underrun_cnt);
        end
        n_cmp++;
        if (pulses !== 9) begin
            n_err++;
            $display("FAIL sat_pulses got %0d want 9", pulses);
        end
        wind_down("sat");
    endtask

    initial begin
        test_reset();
        test_1r1t();
        test_2r2t();
        test_starve_pad();
        test_drain();
        test_reset_mid_run();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
